mem_port_arbiter: RTL and testbench

Shares the single memory port of the four-stage pipeline CPU between the IF-stage instruction fetch and the EX-stage load/store unit. A small FSM registers the winning request, drives the memory-side handshake and returns an acknowledge with read data. It generates stall requests back to the pipeline and a timeout error. The arbiter sits between pipeline_cpu and the unified instruction/data memory.

---
 rtl/arb_pkg.sv | 35 +++
 rtl/arb_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e : FSM state encoding
//   owner_sel_e : owner select returned by the arbitration function
//   DEF_*       : default starvation limit and timeout
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } owner_sel_e;

  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 64;

  // Data normally wins; a starved fetch overrides it. Callers pass 0 for
  // the requester that is completing so it cannot be re-granted.
  function automatic owner_sel_e pick_owner(input logic i_pend,
                                            input logic d_pend,
                                            input logic fetch_starved);
    owner_sel_e sel;
    sel = SEL_NONE;
    if (i_pend && fetch_starved) sel = SEL_I;
    else if (d_pend)             sel = SEL_D;
    else if (i_pend)             sel = SEL_I;
    return sel;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle timeout counter for the memory port arbiter.
//   clk, reset_n : clock, async active-low reset
//   start        : a grant happens on this edge, counter restarts at 0
//   busy         : arbiter is in a BUSY state this cycle
//   expire       : this busy cycle is the last one allowed (count TIMEOUT-1)
module arb_watchdog
  import arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic busy,
  output logic expire
);

  logic [7:0] cnt;

  // The abort leaves BUSY at TIMEOUT-1, so the count never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (start) cnt <= '0;
    else if (busy)  cnt <= cnt + 8'd1;
  end

  assign expire = busy && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (i_*) and the
// load/store unit (d_*).
//   clk, reset_n          : clock, async active-low reset
//   i_req/i_addr/i_ack    : fetch request, address, completion pulse
//   d_req/d_we/d_addr/
//   d_wdata/d_ack         : data request, store flag, address, data, completion
//   rdata, err            : read data / timeout flag for the current ack
//   if_stall, ex_stall    : pipeline stall requests
//   mem_req/we/addr/wdata : registered memory-side request
//   mem_ready, mem_rdata  : memory completion and read data
//
// state  | meaning
// IDLE   | no access in flight, arbitrate pending requests
// BUSY_I | fetch access in flight
// BUSY_D | load/store access in flight
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              if_stall,
  output logic              ex_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_nxt;
  owner_sel_e sel;
  logic [3:0] starve_cnt, starve_nxt;
  logic       busy, expire, done_ok, abort, starved;
  logic       grant_i, grant_d;

  assign busy    = (state != IDLE);
  assign done_ok = busy & mem_ready;
  // A ready on the last allowed cycle still counts as a normal completion.
  assign abort   = expire & ~mem_ready;
  assign starved = (starve_cnt == 4'(STARVE_MAX));

  assign i_ack    = (state == BUSY_I) & (mem_ready | expire);
  assign d_ack    = (state == BUSY_D) & (mem_ready | expire);
  assign err      = abort;
  assign rdata    = done_ok ? mem_rdata : '0;
  assign if_stall = i_req & ~i_ack;
  assign ex_stall = d_req & ~d_ack;

  always_comb begin
    sel = SEL_NONE;
    unique case (state)
      IDLE:    sel = pick_owner(i_req, d_req, starved);
      BUSY_I:  if (done_ok) sel = pick_owner(1'b0, d_req, starved);
      BUSY_D:  if (done_ok) sel = pick_owner(i_req, 1'b0, starved);
      default: sel = SEL_NONE;
    endcase
    grant_i = (sel == SEL_I);
    grant_d = (sel == SEL_D);

    state_nxt = state;
    if (grant_i)             state_nxt = BUSY_I;
    else if (grant_d)        state_nxt = BUSY_D;
    else if (i_ack || d_ack) state_nxt = IDLE;
  end

  // A fetch in its own ack cycle is not waiting, so it does not count
  // toward starvation of a back-to-back data grant.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!i_req || grant_i)                    starve_nxt = '0;
    else if (grant_d && if_stall && !starved) starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      mem_req    <= (state_nxt != IDLE);
      if (grant_i) begin
        mem_addr  <= i_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
      end else if (grant_d) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
      end
    end
  end

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (grant_i | grant_d),
    .busy    (busy),
    .expire  (expire)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SMAX = 4, TMO = 64;
  localparam int NEVER = 1000;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_ack, d_ack, err, if_stall, ex_stall, mem_req, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .err(err), .if_stall(if_stall), .ex_stall(ex_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic err; logic [DW-1:0] rdata; int cyc; } ack_t;
  ack_t ack_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;

  // Reference model: owner 0 none, 1 fetch, 2 data; age = busy cycle index.
  int            m_owner = 0, m_age = 0, m_lat = 0, starve = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_we = 1'b0;
  logic [DW-1:0] m_wdata = '0, m_rd = '0;

  // Expected values for the current cycle.
  logic          x_req = 1'b0, x_we = 1'b0, x_ifs = 1'b0, x_exs = 1'b0, x_wd = 1'b0, in_rst = 1'b1;
  logic [AW-1:0] x_addr = '0;
  logic [DW-1:0] x_wdata = '0;

  // Stimulus knobs.
  int            p_i = 0, p_d = 0, lat_mode = 0, fix_lat = -1;
  logic          fix_rd_en = 1'b0, idle_ready = 1'b0, rst_now = 1'b1;
  logic [DW-1:0] fix_rd = '0;
  logic          i_done = 1'b0, d_done = 1'b0;
  logic          st_on = 1'b0, st_seen = 1'b0;
  int            st_dacks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic ack_now, ab, granted, i_pend;
    int   nxt;
    ack_t e;
    cyc++;
    if (i_done) begin i_req = 1'b0; i_done = 1'b0; end
    if (d_done) begin d_req = 1'b0; d_done = 1'b0; end
    if (!i_req && int'($urandom_range(99)) < p_i) begin
      i_req = 1'b1; i_addr = $urandom & ~32'h3;
    end
    if (!d_req && int'($urandom_range(99)) < p_d) begin
      d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom & ~32'h3; d_wdata = $urandom;
    end
    if (rst_now) begin
      reset_n = 1'b0; m_owner = 0; m_age = 0; starve = 0;
      mem_ready = 1'($urandom_range(1)); mem_rdata = $urandom;
      x_req = 1'b0; x_addr = '0; x_we = 1'b0; x_wdata = '0; x_wd = 1'b1;
      x_ifs = i_req; x_exs = d_req; in_rst = 1'b1;
      return;
    end
    reset_n = 1'b1; in_rst = 1'b0;

    ack_now = 1'b0; ab = 1'b0;
    if (m_owner != 0) begin
      mem_ready = (m_age == m_lat); mem_rdata = m_rd;
      if (m_age == m_lat) ack_now = 1'b1;
      else if (m_age == TMO - 1) begin ack_now = 1'b1; ab = 1'b1; end
    end else begin
      mem_ready = idle_ready ? 1'b1 : 1'($urandom_range(1)); mem_rdata = $urandom;
    end
    x_req = (m_owner != 0); x_addr = m_addr; x_we = m_we; x_wdata = m_wdata; x_wd = (m_owner == 2);
    x_ifs = i_req && !(ack_now && m_owner == 1);
    x_exs = d_req && !(ack_now && m_owner == 2);
    if (ack_now) begin
      e.port = m_owner; e.err = ab; e.rdata = ab ? '0 : m_rd; e.cyc = cyc;
      ack_q.push_back(e);
      if (m_owner == 1) i_done = 1'b1; else d_done = 1'b1;
    end

    // Next owner: data first unless fetch starved; a completing owner
    // hands over only to the other side; an abort always goes idle.
    nxt = m_owner;
    if (m_owner == 0) begin
      if (d_req && !(i_req && starve == SMAX)) nxt = 2;
      else if (i_req)                          nxt = 1;
    end else if (ack_now) begin
      nxt = 0;
      if (!ab && m_owner == 2 && i_req) nxt = 1;
      if (!ab && m_owner == 1 && d_req) nxt = 2;
    end
    granted = (nxt != 0) && (m_owner == 0 || ack_now);
    i_pend  = i_req && !(ack_now && m_owner == 1);
    if (!i_req || (granted && nxt == 1)) starve = 0;
    else if (granted && nxt == 2 && i_pend && starve < SMAX) starve++;

    if (granted) begin
      m_age = 0;
      if (nxt == 1) begin m_addr = i_addr; m_we = 1'b0; end
      else begin m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; end
      if (fix_lat >= 0)       m_lat = fix_lat;
      else if (lat_mode == 1) m_lat = (nxt == 2) ? NEVER : 0;
      else                    m_lat = ($urandom_range(19) == 0) ? NEVER : int'($urandom_range(3));
      m_rd = fix_rd_en ? fix_rd : $urandom;
    end else if (m_owner != 0) begin
      m_age++;
    end
    m_owner = nxt;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(negedge clk); step(); end
  endtask

  task automatic drain();
    int k;
    p_i = 0; p_d = 0; k = 0;
    while ((i_req || d_req || m_owner != 0) && k < 300) begin cycles(1); k++; end
    if (k >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: requests still outstanding after %0d cycles", k);
    end
  endtask

  // Monitor: pops the scoreboard when the DUT acknowledges.
  always @(negedge clk) begin
    ack_t e;
    #1;
    while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
      n_chk++; n_fail++;
      $display("FAIL ack_missing: got no ack, expected port %0d ack at cycle %0d", ack_q[0].port, ack_q[0].cyc);
      void'(ack_q.pop_front());
    end
    if (i_ack === 1'b1 || d_ack === 1'b1) begin
      if (ack_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL ack_unexpected: got i_ack=%b d_ack=%b, expected no ack (cycle %0d)", i_ack, d_ack, cyc);
      end else begin
        e = ack_q.pop_front();
        chk("ack_port", 64'({i_ack, d_ack}), 64'((e.port == 1) ? 2'b10 : 2'b01));
        chk("ack_err", 64'(err), 64'(e.err));
        chk("ack_rdata", 64'(rdata), 64'(e.rdata));
      end
      if (st_on && d_ack === 1'b1) st_dacks++;
      if (st_on && i_ack === 1'b1 && !st_seen) begin
        st_seen = 1'b1;
        chk("starve_data_grants", 64'(st_dacks), 64'(SMAX));
      end
    end else begin
      chk("err_without_ack", 64'(err), 64'(0));
    end
    chk("mem_req", 64'(mem_req), 64'(x_req));
    if (x_req || in_rst) begin
      chk("mem_addr", 64'(mem_addr), 64'(x_addr));
      chk("mem_we", 64'(mem_we), 64'(x_we));
      if (x_wd) chk("mem_wdata", 64'(mem_wdata), 64'(x_wdata));
    end
    chk("if_stall", 64'(if_stall), 64'(x_ifs));
    chk("ex_stall", 64'(ex_stall), 64'(x_exs));
  end

  initial begin
    rst_now = 1'b1;
    cycles(3);
    rst_now = 1'b0;

    // single fetch at 0x10, ready on the second busy cycle
    fix_lat = 1; fix_rd_en = 1'b1; fix_rd = 32'h0050_0093;
    @(negedge clk); i_req = 1'b1; i_addr = 32'h10; step();
    cycles(4); drain();
    fix_rd_en = 1'b0;

    // simultaneous fetch and store, memory always ready
    fix_lat = 0;
    @(negedge clk); i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h7; step();
    cycles(4); drain();

    // stray mem_ready while idle, then a load at 0x40
    idle_ready = 1'b1; cycles(2);
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; step();
    cycles(3); idle_ready = 1'b0; drain();

    // memory never ready: timeout abort
    fix_lat = NEVER;
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hdead_beef; step();
    cycles(70); drain();

    // fetch starvation: data always requesting and always timing out
    fix_lat = -1; lat_mode = 1; st_on = 1'b1; p_i = 100; p_d = 100;
    cycles(350);
    st_on = 1'b0;
    chk("starve_fetch_seen", 64'(st_seen), 64'(1));
    drain(); lat_mode = 0;

    // randomized traffic
    p_i = 30; p_d = 30;
    cycles(3000);
    drain();

    // reset in the middle of a data access
    fix_lat = NEVER;
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 32'hc00; step();
    cycles(5);
    rst_now = 1'b1; cycles(2); rst_now = 1'b0;
    fix_lat = 0;
    cycles(4); drain();
    cycles(2);

    chk("ack_queue_empty", 64'(ack_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
